// File: rtl/riscv_pkg.sv
// Shared definitions for the cache-line memory interface.
// Line geometry (words per line, line width, byte-offset bits) and the
// write-back buffer drain FSM state type.
package riscv_pkg;

    localparam int LINE_WORDS  = 8;
    localparam int LINE_BITS   = 256;
    localparam int OFFSET_BITS = 5;
    localparam int WORD_BITS   = LINE_BITS / LINE_WORDS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } wbb_state_t;

endpackage

// File: rtl/wbb_match.sv
// DEPTH-way line-tag compare with youngest-match priority.
// Ports:
//   tags_i    stored line tags, one per slot
//   valid_i   per-slot qualifier (caller may mask slots out)
//   tag_i     lookup tag
//   wr_ptr_i  next allocation slot; slots just below it are the youngest
//   hit_o     some qualified slot matches
//   idx_o     slot of the youngest match (0 when no hit)
module wbb_match #(
    parameter int DEPTH = 2,
    parameter int TW    = 27,
    parameter int PW    = 1
) (
    input  logic [DEPTH-1:0][TW-1:0] tags_i,
    input  logic [DEPTH-1:0]         valid_i,
    input  logic [TW-1:0]            tag_i,
    input  logic [PW-1:0]            wr_ptr_i,
    output logic                     hit_o,
    output logic [PW-1:0]            idx_o
);

    logic [PW-1:0] idx;

    // Walk from oldest slot (wr_ptr - DEPTH == wr_ptr) to youngest (wr_ptr - 1);
    // a later hit overrides an earlier one, so the youngest match wins.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        idx   = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = wr_ptr_i - PW'(k);
            if (valid_i[idx] && (tags_i[idx] == tag_i)) begin
                hit_o = 1'b1;
                idx_o = idx;
            end
        end
    end

endmodule

// File: rtl/dcache_writeback_buffer.sv
// D-cache write-back buffer: queues evicted dirty lines and drains them to
// data memory one line per mem_write/mem_ack handshake. A repeat eviction of
// a queued line overwrites it in place unless that line is currently being
// written. A probe port lets a refill read pick up the youngest held copy.
// Ports:
//   clk, start        clock; start is the async active-low reset
//   wb_valid/addr/line eviction request; wb_ready = buffer not full
//   mem_write/addr/line head line toward memory, mem_ack pops it
//   probe_addr        refill lookup; probe_hit/probe_line combinational
//   wb_empty/wb_count occupancy
module dcache_writeback_buffer
    import riscv_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int LINE_WORDS = riscv_pkg::LINE_WORDS
) (
    input  logic                          clk,
    input  logic                          start,
    input  logic                          wb_valid,
    input  logic [31:0]                   wb_addr,
    input  logic [LINE_WORDS*WORD_BITS-1:0] wb_line,
    output logic                          wb_ready,
    output logic                          mem_write,
    output logic [31:0]                   mem_addr,
    output logic [LINE_WORDS*WORD_BITS-1:0] mem_line,
    input  logic                          mem_ack,
    input  logic [31:0]                   probe_addr,
    output logic                          probe_hit,
    output logic [LINE_WORDS*WORD_BITS-1:0] probe_line,
    output logic                          wb_empty,
    output logic [$clog2(DEPTH):0]        wb_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int LB = LINE_WORDS * WORD_BITS;
    localparam int TW = 32 - OFFSET_BITS;

    logic [DEPTH-1:0][TW-1:0] tag_q;
    logic [DEPTH-1:0][LB-1:0] line_q;
    logic [DEPTH-1:0]         vld_q, vld_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    wbb_state_t               state_q, state_d;

    logic                     head_busy, accept, pop, alloc;
    logic [DEPTH-1:0]         co_vld;
    logic                     co_hit;
    logic [PW-1:0]            co_idx, pr_idx, wr_idx;

    // Offset bits of both addresses are don't-care.
    logic unused_offsets;
    assign unused_offsets = ^{wb_addr[OFFSET_BITS-1:0], probe_addr[OFFSET_BITS-1:0]};

    assign head_busy = (state_q == BUSY);
    assign wb_ready  = (count_q != CW'(DEPTH));
    assign accept    = wb_valid && wb_ready;
    assign pop       = head_busy && mem_ack;

    // The head line is frozen while memory is writing it, so it must not be
    // a coalesce target; a repeat eviction then allocates a fresh slot.
    always_comb begin
        co_vld = vld_q;
        if (head_busy) co_vld[rd_ptr_q] = 1'b0;
    end

    wbb_match #(.DEPTH(DEPTH), .TW(TW), .PW(PW)) u_coalesce (
        .tags_i   (tag_q),
        .valid_i  (co_vld),
        .tag_i    (wb_addr[31:OFFSET_BITS]),
        .wr_ptr_i (wr_ptr_q),
        .hit_o    (co_hit),
        .idx_o    (co_idx)
    );

    wbb_match #(.DEPTH(DEPTH), .TW(TW), .PW(PW)) u_probe (
        .tags_i   (tag_q),
        .valid_i  (vld_q),
        .tag_i    (probe_addr[31:OFFSET_BITS]),
        .wr_ptr_i (wr_ptr_q),
        .hit_o    (probe_hit),
        .idx_o    (pr_idx)
    );

    assign probe_line = probe_hit ? line_q[pr_idx] : '0;

    assign alloc  = accept && !co_hit;
    assign wr_idx = co_hit ? co_idx : wr_ptr_q;

    // Queue bookkeeping: allocation and pop touch different slots whenever
    // both happen, because allocation needs count < DEPTH and pop needs count >= 1.
    always_comb begin
        vld_d    = vld_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (alloc) begin
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + 1'b1;
        end
        case ({alloc, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // GAP forces one idle cycle on mem_write between lines; from GAP the
    // next line is issued directly so back-to-back cost is ack latency + 1.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (count_q != '0) state_d = BUSY;
            BUSY:    if (mem_ack) state_d = GAP;
            GAP:     state_d = (count_q != '0) ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            vld_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
        end else begin
            vld_q    <= vld_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
        end
    end

    // Payload storage needs no reset: it is only observed through valid slots.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_q[wr_idx]  <= wb_addr[31:OFFSET_BITS];
            line_q[wr_idx] <= wb_line;
        end
    end

    assign mem_write = head_busy;
    assign mem_addr  = head_busy ? {tag_q[rd_ptr_q], {OFFSET_BITS{1'b0}}} : '0;
    assign mem_line  = head_busy ? line_q[rd_ptr_q] : '0;
    assign wb_empty  = (count_q == '0);
    assign wb_count  = count_q;

endmodule
